// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 bus bundle carrying its own clock and reset.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        we;
    logic [3:0]  sel;
    logic        stb;
    logic        cyc;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, dat_sm, ack,
        output adr, dat_ms, we, sel, stb, cyc, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, we, sel, stb, cyc, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wb_burst_reader.sv
// Reads NWORDS consecutive words over Wishbone incrementing bursts into a
// first-word-fall-through FIFO; a burst starts only when the FIFO has room for all of it.
module wb_burst_reader #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int unsigned NWORDS     = 2048,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    wshb_if.master      wb_m,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int unsigned IW = $clog2(NWORDS + 1);
    localparam int unsigned LW = $clog2(BURST_LEN + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic [1:0] {IDLE, WAIT_ROOM, BURST, DRAIN} state_e;

    logic clk;
    logic rst;
    assign clk = wb_m.clk;
    assign rst = wb_m.rst;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [31:0]     adr_q, adr_d;
    logic [2:0]      cti_q, cti_d;
    logic            cyc_q, cyc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [CW-1:0]   free;
    logic            push;
    logic            pop;

    function automatic logic [LW-1:0] burst_len(input logic [IW-1:0] idx);
        logic [31:0] left;
        left = 32'(NWORDS) - 32'(idx);
        if (left > 32'(BURST_LEN)) burst_len = LW'(BURST_LEN);
        else                       burst_len = LW'(left);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign free = CW'(FIFO_DEPTH) - count_q;

    // Sequencer: rem_q holds the beats still owed in the current or next burst.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        adr_d   = adr_q;
        cti_d   = cti_q;
        cyc_d   = cyc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    rem_d   = burst_len('0);
                    busy_d  = 1'b1;
                    state_d = WAIT_ROOM;
                end
            end
            WAIT_ROOM: begin
                if (32'(free) >= 32'(rem_q)) begin
                    cyc_d   = 1'b1;
                    adr_d   = BASE_ADR + (32'(idx_q) << 2);
                    cti_d   = (rem_q == LW'(1)) ? CTI_EOB : CTI_INC;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (wb_m.ack) begin
                    push  = 1'b1;
                    idx_d = idx_q + IW'(1);
                    rem_d = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        cyc_d = 1'b0;
                        cti_d = CTI_CLASSIC;
                        if (32'(idx_d) < 32'(NWORDS)) begin
                            rem_d   = burst_len(idx_d);
                            state_d = WAIT_ROOM;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        adr_d = adr_q + 32'd4;
                        cti_d = (rem_q == LW'(2)) ? CTI_EOB : CTI_INC;
                    end
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = out_ready && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rem_q    <= '0;
            adr_q    <= BASE_ADR;
            cti_q    <= CTI_CLASSIC;
            cyc_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            adr_q    <= adr_d;
            cti_q    <= cti_d;
            cyc_q    <= cyc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wb_m.dat_sm;
    end

    assign wb_m.adr    = adr_q;
    assign wb_m.cti    = cti_q;
    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = cyc_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.dat_ms = 32'h0000_0000;
    assign wb_m.sel    = 4'b1111;
    assign wb_m.bte    = 2'b00;

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
endmodule

// File: tb/tb_wb_burst_reader.sv
// Scoreboarded bench for wb_burst_reader against a word-addressed memory slave.
module tb_wb_burst_reader;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int unsigned NW   = 20;
    localparam int unsigned BL   = 8;
    localparam int unsigned FD   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ack_gate = 1'b1;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_burst_reader #(
        .BASE_ADR(BASE), .NWORDS(NW), .BURST_LEN(BL), .FIFO_DEPTH(FD)
    ) dut (
        .wb_m(wb.master),
        .start(start),
        .busy(busy),
        .done(done),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input int unsigned n);
        return 32'hC0DE_0000 + 32'(n);
    endfunction

    assign wb.dat_sm = mem_word(32'((wb.adr - BASE) >> 2));
    assign wb.ack    = wb.cyc & wb.stb & ack_gate;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb [$];
    int beat_idx = 0;
    int last_run_beats = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;
    int ack_mode = 0;
    int rdy_mode = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_cti(input int b);
        if ((b % BL) == BL - 1 || b == NW - 1) return 3'b111;
        return 3'b010;
    endfunction

    // Slave ack pattern and downstream ready, updated just after each edge.
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        ack_gate = (ack_mode == 0) || (cyc_cnt % 3 == 0);
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (rst) begin
            beat_idx = 0;
        end else begin
            if (wb.cyc) begin
                chk("stb", 32'(wb.stb), 32'd1);
                if (beat_idx >= int'(NW)) begin
                    chk("beat_overrun", 32'(beat_idx), 32'(NW - 1));
                end else begin
                    chk("adr", wb.adr, BASE + 32'(beat_idx) * 32'd4);
                    chk("cti", 32'(wb.cti), 32'(exp_cti(beat_idx)));
                end
                if (wb.ack) beat_idx++;
            end else begin
                chk("cti_idle", 32'(wb.cti), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underrun", 32'(sb.size()), 32'd1);
                else                chk("data", out_data, sb.pop_front());
            end
            if (done) begin
                done_cnt++;
                last_run_beats = beat_idx;
                beat_idx = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        for (int n = 0; n < int'(NW); n++) sb.push_back(mem_word(32'(n)));
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_run(input int d0, input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles && done_cnt == d0; i++) step();
        chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        repeat (5) step();
        chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_beats"}, 32'(last_run_beats), 32'(NW));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        step();
        step();
        chk("rst_cyc", 32'(wb.cyc), 32'd0);
        chk("rst_cti", 32'(wb.cti), 32'd0);
        chk("rst_adr", wb.adr, BASE);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("const_sel", 32'(wb.sel), 32'hF);
        chk("const_we", 32'(wb.we), 32'd0);
        rst = 1'b0;

        // Streaming run with ack and ready always high; check start-to-cyc latency.
        ack_mode = 0; rdy_mode = 1;
        step();
        d0 = done_cnt;
        launch();
        chk("lat_cyc1", 32'(wb.cyc), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        step();
        chk("lat_cyc2", 32'(wb.cyc), 32'd1);
        finish_run(d0, 300, "stream");

        // Downstream stalled: only FD words fit, then the reader waits for room.
        rdy_mode = 0;
        step();
        d0 = done_cnt;
        launch();
        repeat (60) step();
        chk("stall_beats", 32'(beat_idx), 32'(FD));
        chk("stall_cyc", 32'(wb.cyc), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_valid", 32'(out_valid), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        rdy_mode = 1;
        finish_run(d0, 300, "stall");

        // Slow slave and random downstream ready.
        ack_mode = 1; rdy_mode = 2;
        step();
        d0 = done_cnt;
        launch();
        finish_run(d0, 800, "slow");

        // Reset while the third beat of the first burst is on the bus.
        ack_mode = 0; rdy_mode = 1;
        step();
        d0 = done_cnt;
        launch();
        step();
        step();
        step();
        chk("pre_rst_cyc", 32'(wb.cyc), 32'd1);
        chk("pre_rst_adr", wb.adr, BASE + 32'd8);
        rst = 1'b1;
        #1;
        chk("arst_cyc", 32'(wb.cyc), 32'd0);
        chk("arst_stb", 32'(wb.stb), 32'd0);
        chk("arst_cti", 32'(wb.cti), 32'd0);
        chk("arst_adr", wb.adr, BASE);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        step();
        step();
        rst = 1'b0;
        chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

        // Fresh run after reset must restart from BASE.
        rdy_mode = 2;
        step();
        d0 = done_cnt;
        launch();
        finish_run(d0, 400, "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
